// File: rtl/rf_wb_arbiter.sv
// Arbitrates the single reg_file write port between pipeline writeback (P, fixed priority)
// and the MDU (M, valid/ready), with a starvation stall and an in-flight MDU scoreboard.
module rf_wb_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADR_WIDTH    = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p_valid,
    input  logic [ADR_WIDTH-1:0]  p_adr,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  m_valid,
    output logic                  m_ready,
    input  logic [ADR_WIDTH-1:0]  m_adr,
    input  logic [DATA_WIDTH-1:0] m_data,
    output logic                  p_stall,
    input  logic                  sb_set,
    input  logic [ADR_WIDTH-1:0]  sb_set_adr,
    input  logic [ADR_WIDTH-1:0]  sb_qa_adr,
    input  logic [ADR_WIDTH-1:0]  sb_qb_adr,
    output logic                  sb_busy_a,
    output logic                  sb_busy_b,
    output logic                  writeEnable,
    output logic [ADR_WIDTH-1:0]  writeAdr,
    output logic [DATA_WIDTH-1:0] writeData
);
    localparam int SB_ENTRIES = 2 ** ADR_WIDTH;
    localparam int CNT_W      = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;

    typedef enum logic {NORMAL, STALL} state_t;

    typedef struct packed {
        logic [ADR_WIDTH-1:0]  adr;
        logic [DATA_WIDTH-1:0] data;
    } wr_req_t;

    state_t              state, stateNext;
    logic [CNT_W-1:0]    starveCnt, starveCntNext;
    logic                grant;
    wr_req_t             grantReq;
    logic                mAccept;
    logic [SB_ENTRIES-1:0] sbBits;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= NORMAL;
            starveCnt <= '0;
            p_stall   <= 1'b0;
        end else begin
            state     <= stateNext;
            starveCnt <= starveCntNext;
            p_stall   <= (stateNext == STALL);
        end
    end

    // M blocked means P holds the port; the counter runs only while that persists.
    always_comb begin
        stateNext     = state;
        starveCntNext = '0;
        case (state)
            NORMAL: begin
                if (m_valid && p_valid) begin
                    if (starveCnt == CNT_W'(STARVE_LIMIT - 1))
                        stateNext = STALL;
                    else
                        starveCntNext = starveCnt + CNT_W'(1);
                end
            end
            STALL:   stateNext = NORMAL;
            default: stateNext = NORMAL;
        endcase
    end

    always_comb begin
        m_ready  = 1'b0;
        grant    = 1'b0;
        grantReq = '0;
        case (state)
            NORMAL: begin
                if (p_valid) begin
                    grant    = 1'b1;
                    grantReq = '{adr: p_adr, data: p_data};
                end else if (m_valid) begin
                    grant    = 1'b1;
                    m_ready  = 1'b1;
                    grantReq = '{adr: m_adr, data: m_data};
                end
            end
            STALL: begin
                if (m_valid) begin
                    grant    = 1'b1;
                    m_ready  = 1'b1;
                    grantReq = '{adr: m_adr, data: m_data};
                end
            end
            default: ;
        endcase
    end

    assign mAccept = m_valid && m_ready;

    // x0 writes still complete the handshake but never reach the register file.
    always_ff @(posedge clk) begin
        if (rst) begin
            writeEnable <= 1'b0;
            writeAdr    <= '0;
            writeData   <= '0;
        end else begin
            writeEnable <= grant && (grantReq.adr != '0);
            if (grant) begin
                writeAdr  <= grantReq.adr;
                writeData <= grantReq.data;
            end
        end
    end

    // Set is written last so it overrides a same-cycle clear of the same entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            sbBits <= '0;
        end else begin
            if (mAccept)
                sbBits[m_adr] <= 1'b0;
            if (sb_set && (sb_set_adr != '0))
                sbBits[sb_set_adr] <= 1'b1;
        end
    end

    assign sb_busy_a = (sb_qa_adr != '0) && sbBits[sb_qa_adr];
    assign sb_busy_b = (sb_qb_adr != '0) && sbBits[sb_qb_adr];
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: reset, P/M writes, starvation stall, x0 and scoreboard.
module tb_rf_wb_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          p_valid, m_valid, m_ready, p_stall;
    logic [AW-1:0] p_adr, m_adr, sb_set_adr, sb_qa_adr, sb_qb_adr;
    logic [DW-1:0] p_data, m_data;
    logic          sb_set, sb_busy_a, sb_busy_b;
    logic          writeEnable;
    logic [AW-1:0] writeAdr;
    logic [DW-1:0] writeData;

    int checks = 0;
    int errors = 0;

    rf_wb_arbiter #(.DATA_WIDTH(DW), .ADR_WIDTH(AW), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .p_valid(p_valid), .p_adr(p_adr), .p_data(p_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_adr(m_adr), .m_data(m_data),
        .p_stall(p_stall),
        .sb_set(sb_set), .sb_set_adr(sb_set_adr),
        .sb_qa_adr(sb_qa_adr), .sb_qb_adr(sb_qb_adr),
        .sb_busy_a(sb_busy_a), .sb_busy_b(sb_busy_b),
        .writeEnable(writeEnable), .writeAdr(writeAdr), .writeData(writeData)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        p_valid = 0; p_adr = 0; p_data = 0;
        m_valid = 0; m_adr = 0; m_data = 0;
        sb_set = 0; sb_set_adr = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1; p_valid = 1; m_valid = 1; p_adr = 3; m_adr = 4;
        sb_qa_adr = 3; sb_qb_adr = 4;
        step(); step();
        checks++;
        if (writeEnable !== 1'b0 || writeAdr !== '0 || writeData !== '0 || p_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: we=%b adr=%0d data=%h stall=%b, want all 0",
                     writeEnable, writeAdr, writeData, p_stall);
        end
        checks++;
        if (sb_busy_a !== 1'b0 || sb_busy_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_sb: busy_a=%b busy_b=%b, want 0 0", sb_busy_a, sb_busy_b);
        end
        rst = 0; idle();
        step();
    endtask

    task automatic test_p_write();
        p_valid = 1; p_adr = 5; p_data = 32'hDEADBEEF;
        step();
        p_valid = 0;
        checks++;
        if (writeEnable !== 1'b1 || writeAdr !== 5'd5 || writeData !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL p_write: we=%b adr=%0d data=%h, want 1 5 deadbeef",
                     writeEnable, writeAdr, writeData);
        end
        step();
        checks++;
        if (writeEnable !== 1'b0 || writeAdr !== 5'd5 || writeData !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL p_hold: we=%b adr=%0d data=%h, want 0 5 deadbeef",
                     writeEnable, writeAdr, writeData);
        end
    endtask

    task automatic test_m_write();
        sb_set = 1; sb_set_adr = 7; sb_qa_adr = 7;
        step();
        sb_set = 0;
        checks++;
        if (sb_busy_a !== 1'b1) begin
            errors++;
            $display("FAIL sb_set7: busy_a=%b, want 1", sb_busy_a);
        end
        m_valid = 1; m_adr = 7; m_data = 32'h00001234;
        #1;
        checks++;
        if (m_ready !== 1'b1) begin
            errors++;
            $display("FAIL m_ready_alone: got %b, want 1", m_ready);
        end
        step();
        m_valid = 0;
        checks++;
        if (writeEnable !== 1'b1 || writeAdr !== 5'd7 || writeData !== 32'h00001234) begin
            errors++;
            $display("FAIL m_write: we=%b adr=%0d data=%h, want 1 7 00001234",
                     writeEnable, writeAdr, writeData);
        end
        checks++;
        if (sb_busy_a !== 1'b0) begin
            errors++;
            $display("FAIL sb_clear7: busy_a=%b, want 0", sb_busy_a);
        end
    endtask

    task automatic test_starve();
        logic          expStall;
        logic [AW-1:0] expAdr;
        logic [DW-1:0] expData;
        m_valid = 1; m_adr = 3; m_data = 32'h0000CAFE;
        for (int c = 1; c <= 6; c++) begin
            p_valid = 1; p_adr = AW'(10 + c); p_data = 32'h100 + DW'(c);
            #1;
            expStall = (c == 5);
            checks++;
            if (p_stall !== expStall || m_ready !== expStall) begin
                errors++;
                $display("FAIL starve_cycle%0d: stall=%b m_ready=%b, want %b %b",
                         c, p_stall, m_ready, expStall, expStall);
            end
            step();
            expAdr  = (c == 5) ? 5'd3 : AW'(10 + c);
            expData = (c == 5) ? 32'h0000CAFE : 32'h100 + DW'(c);
            checks++;
            if (writeEnable !== 1'b1 || writeAdr !== expAdr || writeData !== expData) begin
                errors++;
                $display("FAIL starve_write%0d: we=%b adr=%0d data=%h, want 1 %0d %h",
                         c, writeEnable, writeAdr, writeData, expAdr, expData);
            end
        end
        idle();
        step();
    endtask

    task automatic test_x0();
        p_valid = 1; p_adr = 0; p_data = 32'h55;
        step();
        p_valid = 0;
        checks++;
        if (writeEnable !== 1'b0) begin
            errors++;
            $display("FAIL p_x0: we=%b, want 0", writeEnable);
        end
        m_valid = 1; m_adr = 0; m_data = 32'h66;
        #1;
        checks++;
        if (m_ready !== 1'b1) begin
            errors++;
            $display("FAIL m_x0_ready: got %b, want 1", m_ready);
        end
        step();
        m_valid = 0;
        checks++;
        if (writeEnable !== 1'b0) begin
            errors++;
            $display("FAIL m_x0: we=%b, want 0", writeEnable);
        end
    endtask

    task automatic test_sb_setwins();
        sb_set = 1; sb_set_adr = 9;
        m_valid = 1; m_adr = 9; m_data = 32'h99;
        sb_qa_adr = 9; sb_qb_adr = 0;
        step();
        idle();
        checks++;
        if (sb_busy_a !== 1'b1 || sb_busy_b !== 1'b0) begin
            errors++;
            $display("FAIL sb_set_wins: busy_a=%b busy_b=%b, want 1 0", sb_busy_a, sb_busy_b);
        end
        sb_set = 1; sb_set_adr = 0;
        step();
        sb_set = 0;
        checks++;
        if (sb_busy_b !== 1'b0) begin
            errors++;
            $display("FAIL sb_x0: busy_b=%b, want 0", sb_busy_b);
        end
    endtask

    task automatic test_reset_midop();
        p_valid = 1; m_valid = 1; p_adr = 2; m_adr = 4; sb_qa_adr = 9;
        step(); step();
        rst = 1;
        step();
        rst = 0;
        checks++;
        if (sb_busy_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_sb_mid: busy_a=%b, want 0", sb_busy_a);
        end
        for (int c = 1; c <= 5; c++) begin
            #1;
            checks++;
            if (p_stall !== (c == 5)) begin
                errors++;
                $display("FAIL reset_cnt_cycle%0d: stall=%b, want %b", c, p_stall, (c == 5));
            end
            step();
        end
        idle();
        step();
    endtask

    initial begin
        test_reset();
        test_p_write();
        test_m_write();
        test_starve();
        test_x0();
        test_sb_setwins();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
